ctrl_pipe_reg: RTL and testbench

Parametrised pipeline register for per-instruction control bundles (RegWrite, ResultSrc, MemWrite, ...), generalising the fixed single-stage MEM→WB control register. It implements a chain of `DEPTH` stages, each with a valid bit, a stall (hold) input and a flush (bubble-insert) input. Side-effecting bits of bubbles are forced inactive. It sits between pipeline stages and is driven by the hazard unit.

---
 rtl/ctrl_pipe_reg.sv | 133 +++++++++++++
 tb/tb_ctrl_pipe_reg.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_reg.sv
// ctrl_pipe_reg: DEPTH-stage control-bundle pipeline register with per-stage valid, stall and flush.
// Optional performance counters (stall_cnt, bubble_cnt) are built when CTRL_PIPE_PERF_EN is defined.
module ctrl_pipe_reg #(
  parameter int              WIDTH     = 3,
  parameter int              DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] KILL_MASK = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_ctrl,
  output logic             in_ready,
  input  logic [DEPTH-1:0] stall,
  input  logic [DEPTH-1:0] flush,
  output logic [DEPTH-1:0] stage_valid,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_ctrl
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      bubble_cnt
`endif
);

  logic [DEPTH-1:0] hold_s;
  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] c_q [DEPTH];
  logic [WIDTH-1:0] c_d [DEPTH];

  // Hold of stage i is the OR of its own stall and every later stall.
  always_comb begin
    hold_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic acc;
      acc = 1'b0;
      for (int j = i; j < DEPTH; j++) begin
        acc = acc | stall[j];
      end
      hold_s[i] = acc;
    end
  end

  // Per-stage next state: flush beats hold; a stage behind a frozen upstream takes a bubble.
  always_comb begin
    v_d = v_q;
    for (int i = 0; i < DEPTH; i++) begin
      c_d[i] = c_q[i];
    end
    if (flush[0]) begin
      v_d[0] = 1'b0;
      c_d[0] = RESET_VAL;
    end else if (!hold_s[0]) begin
      v_d[0] = in_valid;
      c_d[0] = in_ctrl;
    end else begin
      v_d[0] = v_q[0];
      c_d[0] = c_q[0];
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (flush[i]) begin
        v_d[i] = 1'b0;
        c_d[i] = RESET_VAL;
      end else if (hold_s[i]) begin
        v_d[i] = v_q[i];
        c_d[i] = c_q[i];
      end else if (hold_s[i-1]) begin
        v_d[i] = 1'b0;
        c_d[i] = RESET_VAL;
      end else begin
        v_d[i] = v_q[i-1];
        c_d[i] = c_q[i-1];
      end
    end
  end

  // Stage registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        c_q[i] <= RESET_VAL;
      end
    end else begin
      v_q <= v_d;
      for (int i = 0; i < DEPTH; i++) begin
        c_q[i] <= c_d[i];
      end
    end
  end

  assign in_ready    = ~hold_s[0];
  assign stage_valid = v_q;
  assign out_valid   = v_q[DEPTH-1];
  // Side-effecting bits are suppressed only at the output; stored ctrl is left untouched.
  assign out_ctrl    = c_q[DEPTH-1] & ~(v_q[DEPTH-1] ? {WIDTH{1'b0}} : KILL_MASK);

`ifdef CTRL_PIPE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (hold_s[0] && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (!v_q[DEPTH-1] && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end else begin
      bubble_cnt_d = bubble_cnt_q;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_pipe_reg.sv
// Self-checking bench for ctrl_pipe_reg (DEPTH=3, WIDTH=3, RESET_VAL=3'b010, KILL_MASK=3'b001).
// Table-driven cycle vectors, a scoreboarded random-stall stream, and hand-written corner sequences.
module tb_ctrl_pipe_reg;
  localparam int         W  = 3;
  localparam int         D  = 3;
  localparam logic [2:0] RV = 3'b010;
  localparam logic [2:0] KM = 3'b001;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_ctrl = '0;
  logic         in_ready;
  logic [D-1:0] stall = '0;
  logic [D-1:0] flush = '0;
  logic [D-1:0] stage_valid;
  logic         out_valid;
  logic [W-1:0] out_ctrl;
`ifdef CTRL_PIPE_PERF_EN
  logic [31:0]  stall_cnt;
  logic [31:0]  bubble_cnt;
`endif

  ctrl_pipe_reg #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV), .KILL_MASK(KM)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ctrl(in_ctrl),
    .in_ready(in_ready), .stall(stall), .flush(flush), .stage_valid(stage_valid),
    .out_valid(out_valid), .out_ctrl(out_ctrl)
`ifdef CTRL_PIPE_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       iv;
    logic [2:0] ic;
    logic [2:0] st;
    logic [2:0] fl;
    logic       rdy;
    logic [2:0] sv;
    logic       ov;
    logic [2:0] oc;
  } vec_t;

  vec_t       tbl[17];
  logic [2:0] sb_q[$];

  // Reset for two edges, then check reset state; returns at posedge+1 with reset released.
  task automatic do_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_ctrl  = 3'b000;
    stall    = 3'b000;
    flush    = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stage_valid", 32'(stage_valid), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_ctrl", 32'(out_ctrl), 32'h2);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [2:0] nxt;
    logic [2:0] exp_c;
    int         drain;

    // cycle vectors: inputs before the edge, expected state after it
    tbl[0]  = '{1'b1, 3'd1, 3'b000, 3'b000, 1'b1, 3'b001, 1'b0, 3'b010};
    tbl[1]  = '{1'b1, 3'd2, 3'b000, 3'b000, 1'b1, 3'b011, 1'b0, 3'b010};
    tbl[2]  = '{1'b1, 3'd3, 3'b000, 3'b000, 1'b1, 3'b111, 1'b1, 3'b001};
    tbl[3]  = '{1'b1, 3'd4, 3'b000, 3'b000, 1'b1, 3'b111, 1'b1, 3'b010};
    tbl[4]  = '{1'b1, 3'd5, 3'b100, 3'b000, 1'b0, 3'b111, 1'b1, 3'b010};
    tbl[5]  = '{1'b1, 3'd5, 3'b100, 3'b000, 1'b0, 3'b111, 1'b1, 3'b010};
    tbl[6]  = '{1'b1, 3'd5, 3'b000, 3'b000, 1'b1, 3'b111, 1'b1, 3'b011};
    tbl[7]  = '{1'b1, 3'd6, 3'b010, 3'b000, 1'b0, 3'b011, 1'b0, 3'b010};
    tbl[8]  = '{1'b1, 3'd6, 3'b000, 3'b000, 1'b1, 3'b111, 1'b1, 3'b100};
    tbl[9]  = '{1'b1, 3'd7, 3'b010, 3'b010, 1'b0, 3'b001, 1'b0, 3'b010};
    tbl[10] = '{1'b0, 3'd7, 3'b000, 3'b000, 1'b1, 3'b010, 1'b0, 3'b010};
    tbl[11] = '{1'b1, 3'd3, 3'b000, 3'b000, 1'b1, 3'b101, 1'b1, 3'b110};
    tbl[12] = '{1'b0, 3'd0, 3'b000, 3'b000, 1'b1, 3'b010, 1'b0, 3'b110};
    tbl[13] = '{1'b0, 3'd0, 3'b000, 3'b000, 1'b1, 3'b100, 1'b1, 3'b011};
    tbl[14] = '{1'b0, 3'd0, 3'b100, 3'b100, 1'b0, 3'b000, 1'b0, 3'b010};
    tbl[15] = '{1'b0, 3'd0, 3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 3'b000};
    tbl[16] = '{1'b1, 3'd5, 3'b001, 3'b001, 1'b0, 3'b000, 1'b0, 3'b000};

    do_reset();

    for (int k = 0; k < 17; k++) begin
      in_valid = tbl[k].iv;
      in_ctrl  = tbl[k].ic;
      stall    = tbl[k].st;
      flush    = tbl[k].fl;
      #2;
      check($sformatf("vec%0d_in_ready", k), 32'(in_ready), 32'(tbl[k].rdy));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_stage_valid", k), 32'(stage_valid), 32'(tbl[k].sv));
      check($sformatf("vec%0d_out_valid", k), 32'(out_valid), 32'(tbl[k].ov));
      check($sformatf("vec%0d_out_ctrl", k), 32'(out_ctrl), 32'(tbl[k].oc));
    end

    // Random stalls on every stage; every accepted bundle must emerge once, in order.
    do_reset();
    nxt = 3'd1;
    sb_q.delete();
    for (int cyc = 0; cyc < 70; cyc++) begin
      in_valid = (cyc < 50);
      in_ctrl  = nxt;
      stall    = {($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0)};
      flush    = 3'b000;
      if (cyc >= 50) stall = 3'b000;
      #2;
      if (in_valid && in_ready) begin
        sb_q.push_back(nxt);
        nxt = nxt + 3'd1;
      end
      if (out_valid && !stall[D-1]) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_out", 32'(out_ctrl), 32'hFFFF_FFFF);
        end else begin
          exp_c = sb_q.pop_front();
          check("sb_out_ctrl", 32'(out_ctrl), 32'(exp_c));
        end
      end
      @(posedge clk);
      #1;
    end
    drain = sb_q.size();
    check("sb_drained", 32'(drain), 32'h0);

    // Reset asserted while stalled and flushing: all stages become bubbles.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_ctrl  = 3'(k + 5);
      @(posedge clk);
      #1;
    end
    check("pre_rst_stage_valid", 32'(stage_valid), 32'h7);
    stall   = 3'b100;
    flush   = 3'b010;
    reset_n = 1'b0;
    #2;
    check("midrst_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    check("midrst_stage_valid", 32'(stage_valid), 32'h0);
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    check("midrst_out_ctrl", 32'(out_ctrl), 32'h2);
    reset_n = 1'b1;
    stall   = 3'b000;
    flush   = 3'b000;

`ifdef CTRL_PIPE_PERF_EN
    do_reset();
    check("perf_rst_stall", stall_cnt, 32'h0);
    check("perf_rst_bubble", bubble_cnt, 32'h0);
    for (int k = 0; k < 4; k++) begin
      in_valid = (k != 0);
      in_ctrl  = 3'd1;
      @(posedge clk);
      #1;
    end
    stall = 3'b100;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("perf_stall_cnt", stall_cnt, 32'd5);
    check("perf_bubble_cnt", bubble_cnt, 32'd4);
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    @(posedge clk);
    #1;
    check("perf_stall_sat", stall_cnt, 32'hFFFF_FFFF);
    stall = 3'b000;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
